// File: rtl/xbar_out_serializer_if.sv
// Write/swap/status bundle between the crossbar switching stage and the output serializer.
interface xbar_out_serializer_if #(
  parameter int unsigned PORTS = 4,
  parameter int unsigned SLOTS = 4,
  parameter int unsigned DW    = 8
);
  localparam int unsigned CW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned AW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic             wr_en;
  logic [CW-1:0]    wr_cs;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             bank_swap;
  logic [PORTS-1:0] serial_out;
  logic             busy;
  logic             frame_done;
  logic             underrun;

  modport master (
    output wr_en, wr_cs, wr_addr, wr_data, bank_swap,
    input  serial_out, busy, frame_done, underrun
  );

  modport slave (
    input  wr_en, wr_cs, wr_addr, wr_data, bank_swap,
    output serial_out, busy, frame_done, underrun
  );
endinterface

// File: rtl/xbar_out_serializer.sv
// Crossbar output transmitter: double-banked slot buffer shifted out on PORTS serial lanes.
// Optional per-slot even-parity bit enabled by defining XBAR_OUT_PARITY_EN.
module xbar_out_serializer #(
  parameter int unsigned PORTS = 4,
  parameter int unsigned SLOTS = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  xbar_out_serializer_if.slave bus
);

  localparam int unsigned CW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned AW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
`ifdef XBAR_OUT_PARITY_EN
  localparam int unsigned SLOT_LEN = DW + 2;
`else
  localparam int unsigned SLOT_LEN = DW + 1;
`endif
  localparam int unsigned BW = $clog2(SLOT_LEN);
  localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_LEN - 1);
  localparam logic [AW-1:0] LAST_SLOT = AW'(SLOTS - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_wbank, w_wbank_nxt;
  logic             r_pending, w_pending_nxt;
  logic             r_underrun, w_underrun_nxt;
  logic [AW-1:0]    r_slot, w_slot_nxt;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic             w_frame_end;
  logic             w_start;
  logic             w_rbank_nxt;

  logic [PORTS-1:0] r_serial, w_serial_nxt;
  logic             r_busy;
  logic             r_frame_done, w_frame_done_nxt;

  logic             r_valid [2][PORTS][SLOTS];
  logic [DW-1:0]    r_data  [2][PORTS][SLOTS];

  logic                w_ent_valid [PORTS];
  logic [DW-1:0]       w_ent_data  [PORTS];
  logic [SLOT_LEN-1:0] w_word      [PORTS];

  assign w_frame_end = (r_state == StSend) && (r_bit == LAST_BIT) && (r_slot == LAST_SLOT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wbank    <= 1'b0;
      r_pending  <= 1'b0;
      r_underrun <= 1'b0;
      r_slot     <= '0;
      r_bit      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wbank    <= w_wbank_nxt;
      r_pending  <= w_pending_nxt;
      r_underrun <= w_underrun_nxt;
      r_slot     <= w_slot_nxt;
      r_bit      <= w_bit_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_wbank_nxt    = r_wbank;
    w_pending_nxt  = r_pending;
    w_underrun_nxt = r_underrun;
    w_slot_nxt     = r_slot;
    w_bit_nxt      = r_bit;
    w_start        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.bank_swap) w_start = 1'b1;
      end
      StSend: begin
        if (w_frame_end) begin
          // A swap landing on the last bit counts as pending and chains the next frame.
          if (r_pending || bus.bank_swap) w_start = 1'b1;
          else                            w_state_nxt = StIdle;
          if (r_pending && bus.bank_swap) w_underrun_nxt = 1'b1;
          w_pending_nxt = 1'b0;
          w_slot_nxt    = '0;
          w_bit_nxt     = '0;
        end else begin
          if (r_bit == LAST_BIT) begin
            w_bit_nxt  = '0;
            w_slot_nxt = r_slot + 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
          if (bus.bank_swap) begin
            if (r_pending) w_underrun_nxt = 1'b1;
            else           w_pending_nxt  = 1'b1;
          end
        end
      end
    endcase
    if (w_start) begin
      w_state_nxt = StSend;
      w_wbank_nxt = ~r_wbank;
      w_slot_nxt  = '0;
      w_bit_nxt   = '0;
    end
  end

  // Output logic: next line value for the bit the counters will point at
  always_comb begin
    w_rbank_nxt      = ~w_wbank_nxt;
    w_frame_done_nxt = (w_state_nxt == StSend) && (w_bit_nxt == LAST_BIT) &&
                       (w_slot_nxt == LAST_SLOT);
    w_serial_nxt     = '0;
    for (int p = 0; p < int'(PORTS); p++) begin
      w_ent_valid[p] = r_valid[w_rbank_nxt][p][w_slot_nxt];
      w_ent_data[p]  = r_data[w_rbank_nxt][p][w_slot_nxt];
      // Forward a write that lands in the bank being handed over on this same edge.
      if (bus.wr_en && (bus.wr_cs == CW'(p)) && (bus.wr_addr == w_slot_nxt) &&
          (r_wbank == w_rbank_nxt)) begin
        w_ent_valid[p] = 1'b1;
        w_ent_data[p]  = bus.wr_data;
      end
`ifdef XBAR_OUT_PARITY_EN
      w_word[p] = {^{1'b1, w_ent_data[p]}, w_ent_data[p], 1'b1};
`else
      w_word[p] = {w_ent_data[p], 1'b1};
`endif
      w_serial_nxt[p] = (w_state_nxt == StSend) && w_ent_valid[p] && w_word[p][w_bit_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_serial     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_serial     <= w_serial_nxt;
      r_busy       <= (w_state_nxt == StSend);
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < int'(PORTS); p++) begin
          for (int s = 0; s < int'(SLOTS); s++) begin
            r_valid[k][p][s] <= 1'b0;
          end
        end
      end
    end else begin
      if (w_frame_end) begin
        for (int p = 0; p < int'(PORTS); p++) begin
          for (int s = 0; s < int'(SLOTS); s++) begin
            r_valid[~r_wbank][p][s] <= 1'b0;
          end
        end
      end
      if (bus.wr_en) r_valid[r_wbank][bus.wr_cs][bus.wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) r_data[r_wbank][bus.wr_cs][bus.wr_addr] <= bus.wr_data;
  end

  assign bus.serial_out = r_serial;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.underrun   = r_underrun;

endmodule

// File: tb/tb_xbar_out_serializer.sv
// Scoreboard bench for xbar_out_serializer: a bank model queues expected per-cycle line state.
module tb_xbar_out_serializer;
  localparam int PORTS = 4;
  localparam int SLOTS = 4;
  localparam int DW    = 8;
`ifdef XBAR_OUT_PARITY_EN
  localparam int SLOT_LEN = DW + 2;
`else
  localparam int SLOT_LEN = DW + 1;
`endif

  typedef struct packed {
    logic [PORTS-1:0] ser;
    logic             fd;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_out_serializer_if #(.PORTS(PORTS), .SLOTS(SLOTS), .DW(DW)) bus ();

  xbar_out_serializer #(.PORTS(PORTS), .SLOTS(SLOTS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          exp_q[$];
  logic          m_valid [2][PORTS][SLOTS];
  logic [DW-1:0] m_data  [2][PORTS][SLOTS];
  logic          m_wbank;
  int            checks = 0;
  int            errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.wr_en     = 1'b0;
    bus.bank_swap = 1'b0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < PORTS; p++)
        for (int s = 0; s < SLOTS; s++) m_valid[k][p][s] = 1'b0;
    m_wbank = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic model_bit(input int k, input int p, input int s, input int b);
    logic [DW-1:0] d;
    d = m_data[k][p][s];
    if (m_valid[k][p][s] !== 1'b1) return 1'b0;
    if (b == 0) return 1'b1;
    if (b <= DW) return d[b-1];
    return ^{1'b1, d};
  endfunction

  // Queue the frame for the current model write bank, then hand that bank over.
  task automatic push_frame();
    exp_t e;
    int   k;
    k = int'(m_wbank);
    for (int s = 0; s < SLOTS; s++) begin
      for (int b = 0; b < SLOT_LEN; b++) begin
        for (int p = 0; p < PORTS; p++) e.ser[p] = model_bit(k, p, s, b);
        e.fd   = (s == SLOTS - 1) && (b == SLOT_LEN - 1);
        e.busy = 1'b1;
        exp_q.push_back(e);
      end
    end
    for (int p = 0; p < PORTS; p++)
      for (int s = 0; s < SLOTS; s++) m_valid[k][p][s] = 1'b0;
    m_wbank = ~m_wbank;
  endtask

  task automatic push_idle();
    exp_t e;
    e = '0;
    exp_q.push_back(e);
  endtask

  task automatic set_wr(input int p, input int s, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_cs   = 2'(p);
    bus.wr_addr = 2'(s);
    bus.wr_data = d;
    m_valid[m_wbank][p][s] = 1'b1;
    m_data[m_wbank][p][s]  = d;
  endtask

  task automatic write(input int p, input int s, input logic [DW-1:0] d);
    set_wr(p, s, d);
    tick();
    clr_in();
  endtask

  task automatic swap_idle();
    bus.bank_swap = 1'b1;
    push_frame();
    tick();
    clr_in();
  endtask

  task automatic test_reset();
    exp_t e;
    int   i;
    model_clear();
    rst = 1'b1;
    tick();
    checks += 4;
    if (bus.serial_out !== '0) begin errors++; $display("FAIL rst_serial: got %b want 0", bus.serial_out); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", bus.frame_done); end
    if (bus.underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", bus.underrun); end
    rst = 1'b0;
    tick();
    swap_idle();
    push_idle();
    i = 0;
    while (exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL reset_frame[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      tick();
      i++;
    end
  endtask

  task automatic test_single_byte();
    exp_t e;
    int   i;
    write(1, 0, 8'hA5);
    swap_idle();
    push_idle();
    i = 0;
    while (exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL single_byte[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      tick();
      i++;
    end
  endtask

  task automatic test_same_edge();
    exp_t e;
    int   i;
    for (int f = 0; f < 2; f++) begin
      // Second frame hits slot 0, which is on the line the very next cycle.
      if (f == 0) set_wr(3, 2, 8'hFF);
      else        set_wr(2, 0, 8'h3C);
      bus.bank_swap = 1'b1;
      push_frame();
      tick();
      clr_in();
      push_idle();
      i = 0;
      while (exp_q.size() > 0 && i < 500) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
          errors++;
          $display("FAIL same_edge%0d[%0d]: got %b want %b", f, i, {bus.serial_out, bus.frame_done, bus.busy}, e);
        end
        tick();
        i++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   i;
    write(0, 1, 8'h81);
    write(2, 3, 8'h7E);
    swap_idle();
    i = 0;
    while (exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      if (i == 3) set_wr(1, 1, 8'hC3);
      if (i == 4) set_wr(3, 0, 8'h01);
      if (i == 10) begin
        bus.bank_swap = 1'b1;
        push_frame();
        push_idle();
      end
      tick();
      clr_in();
      i++;
    end
  endtask

  task automatic test_last_bit_swap();
    exp_t e;
    int   i;
    write(0, 3, 8'h55);
    swap_idle();
    i = 0;
    while (exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL last_bit_swap[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      if (i == 4) set_wr(2, 1, 8'h0F);
      if (i == SLOTS * SLOT_LEN - 1) begin
        bus.bank_swap = 1'b1;
        push_frame();
        push_idle();
      end
      tick();
      clr_in();
      i++;
    end
  endtask

  task automatic test_underrun();
    exp_t e;
    int   i;
    write(1, 2, 8'h96);
    swap_idle();
    i = 0;
    while (exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL underrun_frames[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      if (i == 2) set_wr(0, 0, 8'h11);
      if (i == 5) begin
        bus.bank_swap = 1'b1;
        push_frame();
        push_idle();
      end
      if (i == 7) begin
        checks++;
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL underrun_early: got %b want 0", bus.underrun); end
      end
      if (i == 8) bus.bank_swap = 1'b1;
      tick();
      clr_in();
      i++;
    end
    tick();
    checks++;
    if (bus.underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", bus.underrun); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   i;
    bit   done;
    checks++;
    if (bus.underrun !== 1'b1) begin errors++; $display("FAIL underrun_held: got %b want 1", bus.underrun); end
    write(1, 1, 8'hF0);
    write(2, 0, 8'hAA);
    swap_idle();
    i = 0;
    done = 1'b0;
    while (!done && exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL pre_reset[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      if (i == 3) set_wr(0, 0, 8'h77);
      if (i == SLOT_LEN + 5) begin
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (bus.serial_out !== '0) begin errors++; $display("FAIL arst_serial: got %b want 0", bus.serial_out); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL arst_underrun: got %b want 0", bus.underrun); end
        clr_in();
        model_clear();
        tick();
        rst  = 1'b0;
        done = 1'b1;
      end else begin
        tick();
        clr_in();
        i++;
      end
    end
    tick();
    swap_idle();
    i = 0;
    while (exp_q.size() > 0 && i < 500) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.serial_out, bus.frame_done, bus.busy} !== e) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %b want %b", i, {bus.serial_out, bus.frame_done, bus.busy}, e);
      end
      if (i == 2) begin
        bus.bank_swap = 1'b1;
        push_frame();
        push_idle();
      end
      tick();
      clr_in();
      i++;
    end
  endtask

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_cs     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.bank_swap = 1'b0;
    test_reset();
    test_single_byte();
    test_same_edge();
    test_back_to_back();
    test_last_bit_swap();
    test_underrun();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
